// File: rtl/bird_controller_pkg.sv
// Shared types and default geometry for the flappy-bird controller.
package bird_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    DEAD = 2'd3
  } state_t;

  localparam int ROWS_DEF       = 16;
  localparam int START_ROW_DEF  = 8;
  localparam int RISE_TICKS_DEF = 2;

endpackage

// File: rtl/bird_controller_flap_edge.sv
// Rising-edge detector for the flap button; stays disarmed after reset
// until the input has been seen low, so a held button cannot fire.
module flap_edge (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic prev;
  logic armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev <= in;
      if (!in) armed <= 1'b1;
    end
  end

  assign pulse = in & ~prev & armed;

endmodule

// File: rtl/bird_controller.sv
// Bird motion FSM: row register, rise counter and pending-flap flag,
// advanced on game ticks; outputs are registered.
module bird_controller
  import bird_controller_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int START_ROW  = START_ROW_DEF,
  parameter int RISE_TICKS = RISE_TICKS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flap,
  input  logic                    tick,
  input  logic                    collide,
  output logic [$clog2(ROWS)-1:0] bird_row,
  output logic                    playing,
  output logic                    game_over
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(RISE_TICKS + 1);
  localparam logic [RW-1:0] TOP_ROW = RW'(ROWS - 1);
  localparam logic [RW-1:0] ST_ROW  = RW'(START_ROW);
  localparam logic [CW-1:0] RT      = CW'(RISE_TICKS);

  state_t        state;
  logic [CW-1:0] rise_cnt;
  logic          pending;
  logic          flap_pulse;
  logic          pend_eff;

  flap_edge u_flap_edge (
    .clk   (clk),
    .reset (reset),
    .in    (flap),
    .pulse (flap_pulse)
  );

  // A pulse arriving on the tick cycle itself counts for that tick.
  assign pend_eff = pending | flap_pulse;

  function automatic logic [RW-1:0] row_inc(input logic [RW-1:0] r);
    return (r == TOP_ROW) ? r : r + RW'(1);
  endfunction

  function automatic logic [RW-1:0] row_dec(input logic [RW-1:0] r);
    return (r == '0) ? r : r - RW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bird_row  <= ST_ROW;
      playing   <= 1'b0;
      game_over <= 1'b0;
      pending   <= 1'b0;
      rise_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bird_row <= ST_ROW;
          if (flap_pulse) begin
            state    <= RISE;
            rise_cnt <= RT;
            playing  <= 1'b1;
          end
        end
        RISE, FALL: begin
          if (collide) begin
            state     <= DEAD;
            pending   <= 1'b0;
            playing   <= 1'b0;
            game_over <= 1'b1;
          end else if (tick) begin
            pending <= 1'b0;
            if (state == RISE) begin
              bird_row <= row_inc(bird_row);
              if (pend_eff) begin
                rise_cnt <= RT;
              end else begin
                rise_cnt <= rise_cnt - CW'(1);
                if (rise_cnt == CW'(1)) state <= FALL;
              end
            end else if (pend_eff) begin
              bird_row <= row_inc(bird_row);
              rise_cnt <= RT - CW'(1);
              state    <= (RISE_TICKS == 1) ? FALL : RISE;
            end else if (bird_row == '0) begin
              state     <= DEAD;
              playing   <= 1'b0;
              game_over <= 1'b1;
            end else begin
              bird_row <= row_dec(bird_row);
            end
          end else if (flap_pulse) begin
            pending <= 1'b1;
          end
        end
        DEAD: begin
          if (flap_pulse) begin
            state     <= IDLE;
            bird_row  <= ST_ROW;
            pending   <= 1'b0;
            game_over <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bird_controller.sv
// Scoreboard bench for bird_controller: each driven cycle queues its
// expected outputs, which are popped and compared after the clock edge.
module tb_bird_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flap = 1'b0;
  logic       tick = 1'b0;
  logic       collide = 1'b0;
  logic [3:0] bird_row;
  logic       playing;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    row;
    int    play;
    int    go;
  } exp_t;

  exp_t sb[$];

  bird_controller dut (
    .clk       (clk),
    .reset     (reset),
    .flap      (flap),
    .tick      (tick),
    .collide   (collide),
    .bird_row  (bird_row),
    .playing   (playing),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic f,
                     input logic t, input logic c,
                     input int er, input int ep, input int eg);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset = r; flap = f; tick = t; collide = c;
    e.tag = tag; e.row = er; e.play = ep; e.go = eg;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      got = sb.pop_front();
      chk({got.tag, "_row"}, int'(bird_row), got.row);
      chk({got.tag, "_playing"}, int'(playing), got.play);
      chk({got.tag, "_game_over"}, int'(game_over), got.go);
    end
  endtask

  initial begin
    int cur;

    // basic start, two rising ticks, then falling
    cyc("rst",        1, 0, 0, 0, 8, 0, 0);
    cyc("idle_arm",   0, 0, 0, 0, 8, 0, 0);
    cyc("idle_tick",  0, 0, 1, 0, 8, 0, 0);
    cyc("idle_col",   0, 0, 0, 1, 8, 0, 0);
    cyc("start",      0, 1, 0, 0, 8, 1, 0);
    cyc("rise1",      0, 0, 1, 0, 9, 1, 0);
    cyc("rise2",      0, 0, 1, 0, 10, 1, 0);
    cyc("fall1",      0, 0, 1, 0, 9, 1, 0);

    // held flap spanning three ticks gives one accepted flap
    cyc("hold_rst",   1, 0, 0, 0, 8, 0, 0);
    cyc("hold_arm",   0, 0, 0, 0, 8, 0, 0);
    cyc("hold_k1",    0, 1, 0, 0, 8, 1, 0);
    cyc("hold_k2",    0, 1, 1, 0, 9, 1, 0);
    cyc("hold_k3",    0, 1, 0, 0, 9, 1, 0);
    cyc("hold_k4",    0, 1, 1, 0, 10, 1, 0);
    cyc("hold_k5",    0, 1, 0, 0, 10, 1, 0);
    cyc("hold_k6",    0, 1, 1, 0, 9, 1, 0);
    for (int k = 7; k <= 10; k++) cyc("hold_tail", 0, 1, 0, 0, 9, 1, 0);

    // fall to the ground and die
    cyc("rel",        0, 0, 0, 0, 9, 1, 0);
    for (int r = 8; r >= 0; r--) cyc("fall_down", 0, 0, 1, 0, r, 1, 0);
    cyc("ground_die", 0, 0, 1, 0, 0, 0, 1);
    cyc("dead_tick",  0, 0, 1, 1, 0, 0, 1);
    cyc("dead_flap",  0, 1, 0, 0, 8, 0, 0);
    cyc("idle_rel",   0, 0, 0, 0, 8, 0, 0);

    // repeated flaps saturate at the ceiling
    cyc("sat_start",  0, 1, 0, 0, 8, 1, 0);
    cur = 8;
    for (int i = 0; i < 10; i++) begin
      cyc("sat_low",  0, 0, 0, 0, cur, 1, 0);
      cur = (cur < 15) ? cur + 1 : 15;
      cyc("sat_flap", 0, 1, 1, 0, cur, 1, 0);
    end
    cyc("sat_hold1",  0, 0, 1, 0, 15, 1, 0);
    cyc("sat_hold2",  0, 0, 1, 0, 15, 1, 0);
    cyc("sat_fall",   0, 0, 1, 0, 14, 1, 0);

    // collide wins over tick in FALL, then restart
    for (int r = 13; r >= 6; r--) cyc("fall_to6", 0, 0, 1, 0, r, 1, 0);
    cyc("col_tick",   0, 0, 1, 1, 6, 0, 1);
    cyc("col_flap",   0, 1, 0, 0, 8, 0, 0);
    cyc("col_rel",    0, 0, 0, 0, 8, 0, 0);

    // flap between ticks in FALL is held pending for the next tick
    cyc("pend_start", 0, 1, 0, 0, 8, 1, 0);
    cyc("pend_r1",    0, 0, 1, 0, 9, 1, 0);
    cyc("pend_r2",    0, 0, 1, 0, 10, 1, 0);
    cyc("pend_set",   0, 1, 0, 0, 10, 1, 0);
    cyc("pend_wait",  0, 0, 0, 0, 10, 1, 0);
    cyc("pend_use",   0, 0, 1, 0, 11, 1, 0);
    cyc("pend_r3",    0, 0, 1, 0, 12, 1, 0);
    cyc("pend_fall",  0, 0, 1, 0, 11, 1, 0);

    // reset mid-game with flap held: no restart until re-pressed
    cyc("mr_flap",    0, 1, 1, 0, 12, 1, 0);
    cyc("mr_hold",    0, 1, 0, 0, 12, 1, 0);
    cyc("mr_rst",     1, 1, 1, 1, 8, 0, 0);
    for (int i = 0; i < 3; i++) cyc("mr_held", 0, 1, 1, 0, 8, 0, 0);
    cyc("mr_low",     0, 0, 0, 0, 8, 0, 0);
    cyc("mr_press",   0, 1, 0, 0, 8, 1, 0);
    cyc("rise_col",   0, 1, 1, 1, 8, 0, 1);
    cyc("dead_held",  0, 1, 0, 0, 8, 0, 1);
    cyc("dead_low",   0, 0, 1, 0, 8, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
